// File: rtl/maxpool_2x2_stream_if.sv
// Stream bundle between the convolution stage, the 2x2 max-pool stage and the next layer.
// slave = pooling stage side, master = the producer/consumer around it.
interface maxpool_2x2_stream_if #(
  parameter int DATA_BIT = 20
);
  logic signed [DATA_BIT-1:0] in_data;
  logic                       valid_in;
  logic signed [DATA_BIT-1:0] out_data;
  logic                       valid_out;
  logic                       frame_done;

  modport master (
    output in_data, valid_in,
    input  out_data, valid_out, frame_done
  );

  modport slave (
    input  in_data, valid_in,
    output out_data, valid_out, frame_done
  );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 signed max pooling over a raster stream, one half-width row buffer.
// Optional macro MAXPOOL_RELU_EN fuses a ReLU onto the pooled output.
module maxpool_2x2_stream #(
  parameter int WIDTH    = 24,
  parameter int HEIGHT   = 24,
  parameter int DATA_BIT = 20
) (
  input  logic clk,
  input  logic rst,
  maxpool_2x2_stream_if.slave bus
);

  localparam int HALF     = WIDTH / 2;
  localparam int W_BITS   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int H_BITS   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IDX_BITS = (HALF   > 1) ? $clog2(HALF)   : 1;

  logic [W_BITS-1:0]          w_count_reg, w_count_next;
  logic [H_BITS-1:0]          h_count_reg, h_count_next;
  logic signed [DATA_BIT-1:0] pair_reg;
  logic signed [DATA_BIT-1:0] row_rd_reg;
  logic signed [DATA_BIT-1:0] out_data_reg;
  logic                       valid_out_reg;
  logic                       frame_done_reg;

  logic signed [DATA_BIT-1:0] row_buf [HALF];

  logic                       col_odd, row_odd, w_last, h_last;
  logic [IDX_BITS-1:0]        buf_idx;
  logic signed [DATA_BIT-1:0] pair_max, pool_max, pool_out;

  assign col_odd = w_count_reg[0];
  assign row_odd = h_count_reg[0];
  assign w_last  = (w_count_reg == W_BITS'(WIDTH - 1));
  assign h_last  = (h_count_reg == H_BITS'(HEIGHT - 1));
  assign buf_idx = IDX_BITS'(w_count_reg >> 1);

  always_comb begin
    w_count_next = w_count_reg;
    h_count_next = h_count_reg;
    if (bus.valid_in) begin
      if (w_last) begin
        w_count_next = '0;
        h_count_next = h_last ? '0 : h_count_reg + 1'b1;
      end else begin
        w_count_next = w_count_reg + 1'b1;
      end
    end
  end

  always_comb begin
    pair_max = (pair_reg > bus.in_data) ? pair_reg : bus.in_data;
    pool_max = (row_rd_reg > pair_max) ? row_rd_reg : pair_max;
`ifdef MAXPOOL_RELU_EN
    pool_out = pool_max[DATA_BIT-1] ? '0 : pool_max;
`else
    pool_out = pool_max;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_count_reg    <= '0;
      h_count_reg    <= '0;
      pair_reg       <= '0;
      out_data_reg   <= '0;
      valid_out_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      valid_out_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      if (bus.valid_in) begin
        w_count_reg <= w_count_next;
        h_count_reg <= h_count_next;
        if (!col_odd) begin
          pair_reg <= bus.in_data;
        end else if (row_odd) begin
          out_data_reg   <= pool_out;
          valid_out_reg  <= 1'b1;
          frame_done_reg <= w_last && h_last;
        end
      end
    end
  end

  // Row buffer read is issued on the even column so the odd column finds it registered;
  // both columns of a pair share the same entry, and reads only occur on odd rows.
  always_ff @(posedge clk) begin
    if (bus.valid_in) begin
      if (col_odd && !row_odd)
        row_buf[buf_idx] <= pair_max;
      if (!col_odd && row_odd)
        row_rd_reg <= row_buf[buf_idx];
    end
  end

  assign bus.out_data   = out_data_reg;
  assign bus.valid_out  = valid_out_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Scoreboard bench for maxpool_2x2_stream: a frame image model predicts every pooled output.
module tb_maxpool_2x2_stream;

  localparam int WIDTH    = 24;
  localparam int HEIGHT   = 24;
  localparam int DATA_BIT = 20;
  localparam int OUTS     = (WIDTH / 2) * (HEIGHT / 2);
  localparam int MIN_V    = -(1 << (DATA_BIT - 1));
  localparam int MAX_V    = (1 << (DATA_BIT - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  maxpool_2x2_stream_if #(.DATA_BIT(DATA_BIT)) bus ();

  maxpool_2x2_stream #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .DATA_BIT(DATA_BIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     done;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     img[HEIGHT][WIDTH];
  int     checks = 0;
  int     errors = 0;
  int     out_count = 0;
  int     done_count = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: maximum of the four image pixels of a window, optional ReLU.
  function automatic longint pool_ref(input int h0, input int w0);
    int m;
    m = img[h0][w0];
    if (img[h0][w0+1]   > m) m = img[h0][w0+1];
    if (img[h0+1][w0]   > m) m = img[h0+1][w0];
    if (img[h0+1][w0+1] > m) m = img[h0+1][w0+1];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return longint'(m);
  endfunction

  // Monitor: pops and compares whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.valid_out) begin
        out_count++;
        if (bus.frame_done) done_count++;
        if (exp_q.size() == 0) begin
          check("queue_depth_at_output", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          $display("out #%0d data=%0d done=%0b cyc=%0d", out_count, bus.out_data, bus.frame_done, cyc);
          check("out_data", bus.out_data, mon_e.data);
          check("frame_done", bus.frame_done, longint'(mon_e.done));
          check("latency_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("frame_done_without_valid", bus.frame_done, 0);
      end
    end
  end

  task automatic gap_cycle();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.in_data  = DATA_BIT'($urandom);
  endtask

  // mode 0: continuous, 1: alternating 1/0, 2: random gaps
  task automatic send_frame(input int npix, input int mode);
    exp_t e;
    for (int p = 0; p < npix; p++) begin
      int h;
      int w;
      h = p / WIDTH;
      w = p % WIDTH;
      if (mode == 1 && p > 0) gap_cycle();
      if (mode == 2 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) gap_cycle();
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.in_data  = DATA_BIT'(img[h][w]);
      if ((h % 2 == 1) && (w % 2 == 1)) begin
        e.data = pool_ref(h - 1, w - 1);
        e.done = (h == HEIGHT - 1) && (w == WIDTH - 1);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name, input int start_outs, input int start_done,
                       input int n_outs, input int n_done);
    gap_cycle();
    repeat (4) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_outputs"}, out_count - start_outs, n_outs);
    check({name, "_frame_done"}, done_count - start_done, n_done);
  endtask

  task automatic fill_ramp();
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++)
        img[h][w] = h * WIDTH + w;
  endtask

  task automatic fill_const(input int v);
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++)
        img[h][w] = v;
  endtask

  task automatic fill_rand();
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++)
        img[h][w] = int'($urandom_range(0, 2 * MAX_V)) - MAX_V;
  endtask

  int so, sd;

  initial begin
    bus.valid_in = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_valid_out", bus.valid_out, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_frame_done", bus.frame_done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous ramp frame
    so = out_count; sd = done_count;
    fill_ramp();
    send_frame(WIDTH * HEIGHT, 0);
    drain("ramp", so, sd, OUTS, 1);

    // Single distinctive window in a -1 background
    so = out_count; sd = done_count;
    fill_const(-1);
    img[0][0] = 5; img[0][1] = -3; img[1][0] = 7; img[1][1] = -100;
    send_frame(WIDTH * HEIGHT, 0);
    drain("window", so, sd, OUTS, 1);

`ifdef MAXPOOL_RELU_EN
    so = out_count; sd = done_count;
    fill_const(-2);
    send_frame(WIDTH * HEIGHT, 0);
    drain("relu_negative", so, sd, OUTS, 1);
`endif

    // Ramp at 50% duty
    so = out_count; sd = done_count;
    fill_ramp();
    send_frame(WIDTH * HEIGHT, 1);
    drain("ramp_half_duty", so, sd, OUTS, 1);

    // Back-to-back random frame then its negation
    so = out_count; sd = done_count;
    fill_rand();
    send_frame(WIDTH * HEIGHT, 0);
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++)
        img[h][w] = -img[h][w];
    send_frame(WIDTH * HEIGHT, 0);
    drain("back_to_back", so, sd, 2 * OUTS, 2);

    // Asynchronous reset after 300 pixels, then a full ramp frame
    fill_rand();
    send_frame(300, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_valid_out", bus.valid_out, 0);
    check("midreset_out_data", bus.out_data, 0);
    check("midreset_frame_done", bus.frame_done, 0);
    check("midreset_pending", exp_q.size(), 0);
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    so = out_count; sd = done_count;
    fill_ramp();
    send_frame(WIDTH * HEIGHT, 0);
    drain("after_reset", so, sd, OUTS, 1);

    // Signed extremes
    so = out_count; sd = done_count;
    fill_rand();
    img[0][0] = MIN_V; img[0][1] = MIN_V; img[1][0] = MIN_V; img[1][1] = MAX_V;
    img[0][2] = MIN_V; img[0][3] = MIN_V; img[1][2] = MIN_V; img[1][3] = MIN_V;
    send_frame(WIDTH * HEIGHT, 0);
    drain("signed_edge", so, sd, OUTS, 1);

    // Random frames with random gaps
    so = out_count; sd = done_count;
    fill_rand();
    send_frame(WIDTH * HEIGHT, 2);
    fill_rand();
    send_frame(WIDTH * HEIGHT, 2);
    drain("random_gaps", so, sd, 2 * OUTS, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_stream.md
Name: maxpool_2x2_stream

Overview:
- Downstream stage of the 5x5 convolution path.
- Consumes the raster-order stream of signed convolution results (24x24 for a 28x28 input) and performs 2x2, stride-2 max pooling.
- Emits a 12x12 raster-order stream to the next layer.
- Uses one half-width row buffer and no frame storage.

Parameters:
- WIDTH, 24, input feature-map width in pixels; must be even.
- HEIGHT, 24, input feature-map height in pixels; must be even.
- DATA_BIT, 20, width of each signed two's-complement pixel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- in_data  input  DATA_BIT  signed convolution result, raster order.
- valid_in  input  1  in_data is valid this cycle; may deassert at any time (gaps allowed).
- out_data  output  DATA_BIT  signed pooled maximum.
- valid_out  output  1  single-cycle strobe: out_data valid.
- frame_done  output  1  single-cycle strobe coincident with the last pooled output of a frame.

Behaviour:
- Reset (rst=0, asynchronous): out_data=0, valid_out=0, frame_done=0, w_count=0, h_count=0, pair_reg=0.
  - Row buffer contents are not cleared; each entry is always written on an even row before it is read.
- A pixel is accepted only on a rising clk with valid_in=1. Cycles with valid_in=0 change no state, except that valid_out and frame_done return to 0.
- Counters:
  - w_count runs 0..WIDTH-1 and wraps to 0 at WIDTH-1, incrementing h_count.
  - h_count runs 0..HEIGHT-1 and wraps to 0 at the frame end.
  - Column parity = w_count[0]; row parity = h_count[0].
- Even column: pair_reg <= in_data.
- Odd column: pmax = signed max(pair_reg, in_data).
  - Even row: row_buf[w_count>>1] <= pmax; no output.
  - Odd row: out_data <= signed max(row_buf[w_count>>1], pmax); valid_out <= 1 on the next edge.
- Latency: valid_out is asserted the cycle after the bottom-right pixel of each 2x2 window is accepted (1-cycle latency).
- Outputs per frame: exactly (WIDTH/2)*(HEIGHT/2) valid_out pulses, in raster order.
- Ties: equal values yield that value. Comparison is signed; 0x80000 (most negative) never beats any other value.
- frame_done is 1 in the same cycle as the valid_out for window (HEIGHT/2-1, WIDTH/2-1).
  - The next accepted pixel starts a new frame at (0,0) with no idle cycle required.
- Back-to-back frames with continuous valid_in are supported; the row buffer is overwritten by the new frame's row 0.
- Reset mid-frame: the partial frame is discarded and no output is produced for it. The first pixel accepted after rst deasserts is treated as pixel (0,0).
- Width rule: row_buf has WIDTH/2 entries of DATA_BIT bits. Index and counter widths are sized from $clog2 of WIDTH and HEIGHT.
- No back-pressure: the consumer must accept every valid_out pulse.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: a ReLU is fused at the output. If the pooled maximum is negative (MSB=1), out_data <= 0; otherwise the maximum is passed through. Timing and valid/frame_done behaviour are unchanged.
- Undefined: out_data is the raw signed maximum, negative values included.

Test Plan:
- Continuous ramp, frame pixel value = h*24+w (WIDTH=HEIGHT=24) -> 144 valid_out pulses. First out_data=25, second=27, last=575. frame_done is 1 only with the 144th pulse.
- Window top-left=5, top-right=-3, bottom-left=7, bottom-right=-100 (rest of frame -1) -> first out_data=7.
  - With MAXPOOL_RELU_EN and an all-negative frame (every pixel -2) -> every out_data=0.
- Same ramp frame with valid_in toggled 1,0,1,0... (50% duty) -> identical 144 output values; each valid_out follows its bottom-right pixel by exactly one clk.
- Two frames back-to-back, frame 2 = frame 1 negated -> second set of 144 outputs equals the per-window max of the negated data, with no contamination from frame 1's row buffer. Two frame_done pulses.
- Assert rst=0 asynchronously mid-cycle after 300 pixels, release, then send a full ramp frame -> valid_out=0 and out_data=0 immediately during reset. Afterwards exactly 144 outputs matching the first-scenario values.
- Signed edge: window {0x80000,0x80000,0x80000,0x7FFFF} -> out_data=0x7FFFF. Window of all 0x80000 -> out_data=0x80000 (MAXPOOL_RELU_EN undefined).
